// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer line reader.
// Defaults describe a 640x480 8-bit framebuffer.
package fb_pkg;

    localparam int ADDR_W = 25;
    localparam int PIX_W  = 8;

    localparam logic [ADDR_W-1:0] FB_BASE_DEF = 25'd0;
    localparam int LINE_WIDTH_DEF = 640;
    localparam int LINE_COUNT_DEF = 480;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int RD_SETTLE_DEF  = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT
    } state_t;

    typedef struct packed {
        logic             last;
        logic [PIX_W-1:0] data;
    } pix_t;

    localparam int PIX_T_W = $bits(pix_t);

endpackage

// File: rtl/fb_line_reader_if.sv
// SDRAM read channel plus pixel stream of the line reader.
// master = reader side, slave = controller/consumer side.
interface fb_line_reader_if;
    import fb_pkg::*;

    logic [ADDR_W-1:0] ch_addr;
    logic              ch_rd;
    logic [PIX_W-1:0]  ch_dout;
    logic              ch_busy;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_last;
    logic              pix_valid;
    logic              pix_ready;

    modport master (
        output ch_addr, ch_rd,
        input  ch_dout, ch_busy,
        output pix_data, pix_last, pix_valid,
        input  pix_ready
    );

    modport slave (
        input  ch_addr, ch_rd,
        output ch_dout, ch_busy,
        input  pix_data, pix_last, pix_valid,
        output pix_ready
    );

endinterface

// File: rtl/fb_line_reader_fifo.sv
// Synchronous FIFO with registered head, sync flush and occupancy count.
// Simultaneous push/pop is honoured at any fill level.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_nxt  = rd_ptr + AW'(pop_ok);

    always_comb begin
        cnt_nxt = count;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_nxt = count + 1'b1;
            2'b01:   cnt_nxt = count - 1'b1;
            default: cnt_nxt = count;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok && !flush) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk_sys) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_nxt;
            count  <= cnt_nxt;
        end
    end

    // Next head bypasses memory when the incoming word becomes the head.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dout <= '0;
        end else if (!flush && cnt_nxt != '0) begin
            dout <= (push_ok && rd_nxt == wr_ptr) ? din : mem[rd_nxt];
        end
    end

endmodule

// File: rtl/fb_line_reader.sv
// Raster-order pixel fetcher: one outstanding SDRAM byte read at a time,
// results buffered in a FIFO and presented as a valid/ready stream.
module fb_line_reader
    import fb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FB_BASE    = FB_BASE_DEF,
    parameter int                LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int                LINE_COUNT = LINE_COUNT_DEF,
    parameter int                FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int                RD_SETTLE  = RD_SETTLE_DEF
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             frame_start,
    fb_line_reader_if.master bus,
    output logic             frame_done,
    output logic             busy
);
    localparam int XW = $clog2(LINE_WIDTH + 1);
    localparam int YW = $clog2(LINE_COUNT + 1);
    localparam int SW = $clog2(RD_SETTLE + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t            state;
    state_t            state_nxt;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [SW-1:0]     settle_cnt;
    logic [ADDR_W-1:0] addr;
    logic              discard;
    logic              x_last;
    logic              y_last;
    logic              issue_ok;
    logic              rd_done;
    logic              capture;
    logic              rewind;
    logic              fifo_push;
    logic              fifo_flush;
    logic              fifo_full;
    logic [CW-1:0]     fifo_count;
    pix_t              fifo_din;
    pix_t              fifo_dout;

    assign x_last   = x == XW'(LINE_WIDTH - 1);
    assign y_last   = y == YW'(LINE_COUNT - 1);
    assign issue_ok = state == S_ISSUE && !fifo_full
                   && !bus.ch_busy && !frame_start;
    assign rd_done  = state == S_WAIT && !bus.ch_busy;
    assign capture  = rd_done && !discard && !frame_start;
    // In-flight reads keep ch_addr until they land; only then rewind.
    assign rewind   = (frame_start && (state == S_IDLE || state == S_ISSUE))
                   || (rd_done && !capture);

    always_ff @(posedge clk_sys) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (frame_start) state_nxt = S_ISSUE;
            S_ISSUE:  if (issue_ok) state_nxt = S_SETTLE;
            S_SETTLE: if (settle_cnt == SW'(RD_SETTLE - 1)) state_nxt = S_WAIT;
            S_WAIT: begin
                if (rd_done) begin
                    state_nxt = (capture && x_last && y_last) ? S_IDLE : S_ISSUE;
                end
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ch_rd  = issue_ok;
        fifo_push  = capture;
        fifo_flush = frame_start;
        busy       = state != S_IDLE;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            addr       <= FB_BASE;
            settle_cnt <= '0;
            discard    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= capture && x_last && y_last;
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;
            if (frame_start && (state == S_SETTLE || (state == S_WAIT && bus.ch_busy)))
                discard <= 1'b1;
            else if (rd_done)
                discard <= 1'b0;
            if (rewind) begin
                x    <= '0;
                y    <= '0;
                addr <= FB_BASE;
            end else if (capture) begin
                x    <= x_last ? '0 : x + 1'b1;
                addr <= (x_last && y_last) ? FB_BASE : addr + 1'b1;
                if (x_last) y <= y_last ? '0 : y + 1'b1;
            end
        end
    end

    assign fifo_din      = '{last: x_last, data: bus.ch_dout};
    assign bus.ch_addr   = addr;
    assign bus.pix_data  = fifo_dout.data;
    assign bus.pix_last  = fifo_dout.last;
    assign bus.pix_valid = fifo_count != '0;

    sync_fifo #(
        .WIDTH(PIX_T_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_sys(clk_sys),
        .reset  (reset),
        .flush  (fifo_flush),
        .push   (fifo_push),
        .din    (fifo_din),
        .pop    (bus.pix_ready),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full)
    );

endmodule

// File: tb/tb_fb_line_reader.sv
// Directed bench for fb_line_reader: 4x2 frame at 0x100000, 4-deep FIFO,
// SDRAM stub returning addr[7:0] after a 3-cycle busy window.
module tb_fb_line_reader;
    import fb_pkg::*;

    localparam logic [ADDR_W-1:0] BASE = 25'h100000;

    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    logic frame_start = 1'b0;
    logic frame_done;
    logic busy;

    fb_line_reader_if bus();

    always #5 clk_sys = ~clk_sys;

    fb_line_reader #(
        .FB_BASE   (BASE),
        .LINE_WIDTH(4),
        .LINE_COUNT(2),
        .FIFO_DEPTH(4),
        .RD_SETTLE (2)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .frame_start(frame_start),
        .bus        (bus),
        .frame_done (frame_done),
        .busy       (busy)
    );

    // SDRAM stub: dout is garbage while busy, real data once busy drops
    int       busy_cnt = 0;
    logic     force_busy = 1'b0;
    logic [7:0] stub_dout = 8'h00;
    logic [7:0] stub_data = 8'h00;

    always @(posedge clk_sys) begin
        if (bus.ch_rd) begin
            stub_data <= bus.ch_addr[7:0];
            stub_dout <= 8'hEE;
            busy_cnt  <= 3;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) stub_dout <= stub_data;
        end
    end

    assign bus.ch_busy = (busy_cnt != 0) || force_busy;
    assign bus.ch_dout = stub_dout;

    logic [8:0]        got[$];
    logic [ADDR_W-1:0] rd_addr[$];
    int done_cnt = 0;
    int bad_rd = 0;

    always @(negedge clk_sys) begin
        if (bus.pix_valid && bus.pix_ready) got.push_back({bus.pix_last, bus.pix_data});
        if (bus.ch_rd) rd_addr.push_back(bus.ch_addr);
        if (frame_done) done_cnt++;
        if (bus.ch_rd && bus.ch_busy) bad_rd++;
    end

    int n_vec = 0;
    int n_fail = 0;

    logic [8:0] exp_pix [8] = '{9'h000, 9'h001, 9'h002, 9'h103,
                                9'h004, 9'h005, 9'h006, 9'h107};

    typedef struct {
        string name;
        int    mode;
        int    exp_npix;
        int    exp_done;
        int    exp_rd;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        frame_start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        repeat (6) tick();
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    function automatic logic ready_of(input int mode, input int c);
        case (mode)
            1:       return (c >= 40) ? ((c % 2) == 1) : 1'b0;
            2:       return (c % 5) == 0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic wait_frame(input string tag, input int mode, input int gb,
                              input int db, input int npix);
        int c = 0;
        while (!(done_cnt > db && got.size() >= gb + npix) && c < 3000) begin
            bus.pix_ready = ready_of(mode, c);
            tick();
            c++;
        end
        chk({tag, "_timeout"}, c < 3000, 1);
        bus.pix_ready = 1'b1;
        repeat (12) tick();
    endtask

    task automatic check_stream(input string tag, input int gb, input int rb, input int db,
                                input int npix, input int nd, input int nrd);
        logic [8:0]        g;
        logic [ADDR_W-1:0] a;
        chk({tag, "_npix"}, got.size() - gb, npix);
        for (int i = 0; i < 8; i++) begin
            g = (gb + i < got.size()) ? got[gb + i] : 9'h1FF;
            chk($sformatf("%s_pix%0d", tag, i), g, exp_pix[i]);
        end
        chk({tag, "_done"}, done_cnt - db, nd);
        chk({tag, "_nrd"}, rd_addr.size() - rb, nrd);
        a = (rd_addr.size() > rb) ? rd_addr[rb] : '1;
        chk({tag, "_first_addr"}, a, BASE);
        a = (rd_addr.size() >= rb + 8) ? rd_addr[rb + 7] : '1;
        chk({tag, "_last_addr"}, a, BASE + 25'd7);
        chk({tag, "_addr_wrap"}, bus.ch_addr, BASE);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_drained"}, bus.pix_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gb;
        int rb;
        int db;
        int c;

        vecs[0] = '{"t1_ready", 0, 8, 1, 8};
        vecs[1] = '{"t3_toggle", 1, 8, 1, 8};
        vecs[2] = '{"slow", 2, 8, 1, 8};

        bus.pix_ready = 1'b0;
        do_reset();
        @(negedge clk_sys);
        chk("rst_valid", bus.pix_valid, 0);
        chk("rst_data", bus.pix_data, 0);
        chk("rst_last", bus.pix_last, 0);
        chk("rst_rd", bus.ch_rd, 0);
        chk("rst_addr", bus.ch_addr, BASE);
        chk("rst_done", frame_done, 0);
        chk("rst_busy", busy, 0);

        for (int v = 0; v < 3; v++) begin
            do_reset();
            gb = got.size();
            rb = rd_addr.size();
            db = done_cnt;
            start_frame();
            wait_frame(vecs[v].name, vecs[v].mode, gb, db, vecs[v].exp_npix);
            check_stream(vecs[v].name, gb, rb, db,
                         vecs[v].exp_npix, vecs[v].exp_done, vecs[v].exp_rd);
        end

        // Stalled consumer: exactly FIFO_DEPTH reads, then fetch resumes
        do_reset();
        gb = got.size();
        rb = rd_addr.size();
        db = done_cnt;
        bus.pix_ready = 1'b0;
        start_frame();
        repeat (80) tick();
        chk("t2_nrd_stalled", rd_addr.size() - rb, 4);
        chk("t2_none_taken", got.size() - gb, 0);
        chk("t2_valid", bus.pix_valid, 1);
        chk("t2_head", {bus.pix_last, bus.pix_data}, 9'h000);
        chk("t2_busy", busy, 1);
        wait_frame("t2", 0, gb, db, 8);
        check_stream("t2", gb, rb, db, 8, 1, 8);

        // Restart while pixel 5 is in WAIT
        do_reset();
        db = done_cnt;
        bus.pix_ready = 1'b1;
        start_frame();
        c = 0;
        do begin
            @(negedge clk_sys);
            c++;
        end while (!(bus.ch_rd && bus.ch_addr == BASE + 25'd5) && c < 200);
        chk("t4_rd5_seen", c < 200, 1);
        @(posedge clk_sys);
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        gb = got.size();
        rb = rd_addr.size();
        @(negedge clk_sys);
        chk("t4_flushed", bus.pix_valid, 0);
        chk("t4_busy", busy, 1);
        chk("t4_no_done", done_cnt - db, 0);
        wait_frame("t4", 0, gb, db, 8);
        check_stream("t4", gb, rb, db, 8, 1, 8);

        // Reset mid-frame, frame_start under reset, then ch_busy held high
        do_reset();
        bus.pix_ready = 1'b1;
        start_frame();
        repeat (14) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk_sys);
        chk("t5_busy", busy, 0);
        chk("t5_valid", bus.pix_valid, 0);
        chk("t5_data", bus.pix_data, 0);
        chk("t5_last", bus.pix_last, 0);
        chk("t5_rd", bus.ch_rd, 0);
        chk("t5_addr", bus.ch_addr, BASE);
        chk("t5_done", frame_done, 0);
        reset = 1'b1;
        frame_start = 1'b1;
        tick();
        reset = 1'b0;
        frame_start = 1'b0;
        @(negedge clk_sys);
        chk("t5_fs_in_reset", busy, 0);
        repeat (6) tick();
        gb = got.size();
        rb = rd_addr.size();
        db = done_cnt;
        force_busy = 1'b1;
        start_frame();
        repeat (30) tick();
        chk("hold_nrd", rd_addr.size() - rb, 0);
        chk("hold_busy", busy, 1);
        force_busy = 1'b0;
        wait_frame("t5", 0, gb, db, 8);
        check_stream("t5", gb, rb, db, 8, 1, 8);

        chk("rd_while_busy", bad_rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
